// File: rtl/header_frame_loader.sv
// Parses SOF/LEN/payload[/checksum] frames from a UART byte stream into a 32 x 32-bit
// big-endian header buffer with a valid/ack handshake. Define HDR_CKSUM_EN to add the XOR checksum byte.
module header_frame_loader #(
    parameter int         N_BYTES = 128,
    parameter logic [7:0] SOF     = 8'hA5,
    parameter int         TIMEOUT = 100000,
    parameter int         CNT_W   = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             rx_valid_i,
    input  logic [7:0]       rx_data_i,
    input  logic             hdr_ack_i,
    input  logic [4:0]       rd_addr_i,
    output logic [31:0]      rd_data_o,
    output logic             hdr_valid_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic [CNT_W-1:0] ovr_cnt_o
);

    localparam int         WORDS    = N_BYTES / 4;
    localparam int         WA       = $clog2(WORDS);
    localparam int         TW       = $clog2(TIMEOUT);
    localparam logic [7:0] LEN_BYTE = 8'(N_BYTES);
    localparam logic [7:0] LAST     = 8'(N_BYTES - 1);
    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT - 1);

`ifdef HDR_CKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CHK, S_HOLD} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_LEN, S_PAYLOAD, S_HOLD} state_t;
`endif

    state_t           r_state;
    logic             r_valid;
    logic [CNT_W-1:0] r_err;
    logic [CNT_W-1:0] r_ovr;
    logic [7:0]       r_cnt;
    logic [TW-1:0]    r_to;
    logic [31:0]      r_mem [WORDS];
`ifdef HDR_CKSUM_EN
    logic [7:0]       r_cksum;
`endif

    logic       w_active;
    logic       w_timeout;
    logic       w_err;
    logic [1:0] w_lane;

    always_comb begin
        w_active = 1'b0;
        w_err    = 1'b0;
        case (r_state)
            S_LEN:     begin
                w_active = 1'b1;
                w_err    = rx_valid_i && (rx_data_i != LEN_BYTE);
            end
            S_PAYLOAD: w_active = 1'b1;
`ifdef HDR_CKSUM_EN
            S_CHK:     begin
                w_active = 1'b1;
                w_err    = rx_valid_i && (rx_data_i != r_cksum);
            end
`endif
            default:   w_active = 1'b0;
        endcase
        w_timeout = w_active && !rx_valid_i && (r_to == TO_MAX);
        w_err     = w_err || w_timeout;
        // Byte 4k lands in bits [31:24]: lane index is the inverted byte offset.
        w_lane    = ~r_cnt[1:0];
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_err   <= '0;
            r_ovr   <= '0;
            r_cnt   <= '0;
            r_to    <= '0;
`ifdef HDR_CKSUM_EN
            r_cksum <= '0;
`endif
        end else begin
            if (w_active && !rx_valid_i && !w_timeout)
                r_to <= r_to + 1'b1;
            else
                r_to <= '0;

            if (w_err && (r_err != {CNT_W{1'b1}}))
                r_err <= r_err + 1'b1;

            if ((r_state == S_HOLD) && rx_valid_i && (r_ovr != {CNT_W{1'b1}}))
                r_ovr <= r_ovr + 1'b1;

            if (w_timeout) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: if (rx_valid_i && (rx_data_i == SOF)) begin
                        r_state <= S_LEN;
`ifdef HDR_CKSUM_EN
                        r_cksum <= '0;
`endif
                    end
                    S_LEN: if (rx_valid_i) begin
                        r_cnt   <= '0;
                        r_state <= (rx_data_i == LEN_BYTE) ? S_PAYLOAD : S_IDLE;
                    end
                    S_PAYLOAD: if (rx_valid_i) begin
                        r_cnt <= r_cnt + 1'b1;
`ifdef HDR_CKSUM_EN
                        r_cksum <= r_cksum ^ rx_data_i;
                        if (r_cnt == LAST)
                            r_state <= S_CHK;
`else
                        if (r_cnt == LAST) begin
                            r_state <= S_HOLD;
                            r_valid <= 1'b1;
                        end
`endif
                    end
`ifdef HDR_CKSUM_EN
                    S_CHK: if (rx_valid_i) begin
                        if (rx_data_i == r_cksum) begin
                            r_state <= S_HOLD;
                            r_valid <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
`endif
                    // An ack wins over a coincident byte: the byte is only an overrun.
                    S_HOLD: if (hdr_ack_i) begin
                        r_state <= S_IDLE;
                        r_valid <= 1'b0;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i && (r_state == S_PAYLOAD) && rx_valid_i)
            r_mem[r_cnt[WA+1:2]][{w_lane, 3'b000} +: 8] <= rx_data_i;
    end

    assign rd_data_o   = r_mem[rd_addr_i[WA-1:0]];
    assign hdr_valid_o = r_valid;
    assign busy_o      = (r_state != S_IDLE) && (r_state != S_HOLD);
    assign err_cnt_o   = r_err;
    assign ovr_cnt_o   = r_ovr;

endmodule

// File: tb/tb_header_frame_loader.sv
// Directed bench for header_frame_loader; adapts the frame format to HDR_CKSUM_EN.
module tb_header_frame_loader;

    localparam int TO = 200;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        rx_valid_i = 1'b0;
    logic [7:0]  rx_data_i = 8'h00;
    logic        hdr_ack_i = 1'b0;
    logic [4:0]  rd_addr_i = 5'd0;
    logic [31:0] rd_data_o;
    logic        hdr_valid_o;
    logic        busy_o;
    logic [7:0]  err_cnt_o;
    logic [7:0]  ovr_cnt_o;

    int checks = 0;
    int errors = 0;
    int expErr = 0;

    typedef struct {
        bit          alt;
        logic [4:0]  addr;
        logic [31:0] word;
    } rdVec_t;

    rdVec_t rdTable [9];

    header_frame_loader #(.N_BYTES(128), .SOF(8'hA5), .TIMEOUT(TO), .CNT_W(8)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .rx_valid_i (rx_valid_i),
        .rx_data_i  (rx_data_i),
        .hdr_ack_i  (hdr_ack_i),
        .rd_addr_i  (rd_addr_i),
        .rd_data_o  (rd_data_o),
        .hdr_valid_o(hdr_valid_o),
        .busy_o     (busy_o),
        .err_cnt_o  (err_cnt_o),
        .ovr_cnt_o  (ovr_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        @(posedge clk_i); #1;
        rx_valid_i = 1'b1;
        rx_data_i  = b;
        @(posedge clk_i); #1;
        rx_valid_i = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    function automatic logic [7:0] payloadByte(input bit alt, input int i);
        return alt ? 8'(i * 7 + 3) : 8'(i);
    endfunction

    // Sends a whole frame; the valid flag must still be low just before the closing byte.
    task automatic sendFrame(input bit alt, input bit badCk);
        logic [7:0] ck;
        ck = 8'h00;
        applyStimulus(8'hA5);
        applyStimulus(8'h80);
        for (int i = 0; i < 128; i++) begin
            ck = ck ^ payloadByte(alt, i);
`ifndef HDR_CKSUM_EN
            if (i == 127) checkOutput("validBeforeLast", {31'd0, hdr_valid_o}, 32'd0);
`endif
            applyStimulus(payloadByte(alt, i));
        end
`ifdef HDR_CKSUM_EN
        checkOutput("validBeforeLast", {31'd0, hdr_valid_o}, 32'd0);
        applyStimulus(badCk ? ~ck : ck);
`else
        if (badCk) $display("[TB] checksum corruption not applicable in this build");
`endif
    endtask

    task automatic readTable(input bit alt);
        for (int i = 0; i < 9; i++) begin
            if (rdTable[i].alt == alt) begin
                rd_addr_i = rdTable[i].addr;
                #1;
                checkOutput($sformatf("rdWord%0d", rdTable[i].addr), rd_data_o, rdTable[i].word);
            end
        end
    endtask

    task automatic ackCycle(input bit withByte);
        @(posedge clk_i); #1;
        hdr_ack_i  = 1'b1;
        rx_valid_i = withByte;
        rx_data_i  = 8'hA5;
        @(posedge clk_i); #1;
        hdr_ack_i  = 1'b0;
        rx_valid_i = 1'b0;
    endtask

    initial begin
        rdTable[0] = '{1'b0, 5'd0,  32'h00010203};
        rdTable[1] = '{1'b0, 5'd1,  32'h04050607};
        rdTable[2] = '{1'b0, 5'd7,  32'h1C1D1E1F};
        rdTable[3] = '{1'b0, 5'd16, 32'h40414243};
        rdTable[4] = '{1'b0, 5'd31, 32'h7C7D7E7F};
        rdTable[5] = '{1'b1, 5'd0,  32'h030A1118};
        rdTable[6] = '{1'b1, 5'd2,  32'h3B424950};
        rdTable[7] = '{1'b1, 5'd31, 32'h676E757C};
        rdTable[8] = '{1'b0, 5'd15, 32'h3C3D3E3F};

        idleCycles(3);
        checkOutput("rstValid", {31'd0, hdr_valid_o}, 32'd0);
        checkOutput("rstBusy",  {31'd0, busy_o}, 32'd0);
        checkOutput("rstErr",   {24'd0, err_cnt_o}, 32'd0);
        checkOutput("rstOvr",   {24'd0, ovr_cnt_o}, 32'd0);
        rst_i = 1'b1;
        idleCycles(2);

        sendFrame(1'b0, 1'b0);
        checkOutput("frame1Valid", {31'd0, hdr_valid_o}, 32'd1);
        checkOutput("frame1Busy",  {31'd0, busy_o}, 32'd0);
        checkOutput("frame1Err",   {24'd0, err_cnt_o}, 32'd0);
        readTable(1'b0);

        applyStimulus(8'hA5);
        applyStimulus(8'h11);
        applyStimulus(8'h22);
        checkOutput("holdOvr",   {24'd0, ovr_cnt_o}, 32'd3);
        checkOutput("holdValid", {31'd0, hdr_valid_o}, 32'd1);
        ackCycle(1'b0);
        checkOutput("ackValid", {31'd0, hdr_valid_o}, 32'd0);
        checkOutput("ackBusy",  {31'd0, busy_o}, 32'd0);
        rd_addr_i = 5'd0; #1;
        checkOutput("bufAfterAck", rd_data_o, 32'h00010203);

        applyStimulus(8'hA5);
        applyStimulus(8'h40);
        expErr++;
        checkOutput("badLenErr",  {24'd0, err_cnt_o}, 32'(expErr));
        checkOutput("badLenBusy", {31'd0, busy_o}, 32'd0);

        sendFrame(1'b1, 1'b0);
        checkOutput("frame2Valid", {31'd0, hdr_valid_o}, 32'd1);
        checkOutput("frame2Err",   {24'd0, err_cnt_o}, 32'(expErr));
        readTable(1'b1);

        ackCycle(1'b1);
        checkOutput("ackRxOvr",   {24'd0, ovr_cnt_o}, 32'd4);
        checkOutput("ackRxValid", {31'd0, hdr_valid_o}, 32'd0);
        applyStimulus(8'h80);
        checkOutput("ackRxNoSof", {31'd0, busy_o}, 32'd0);

`ifdef HDR_CKSUM_EN
        sendFrame(1'b0, 1'b1);
        expErr++;
        checkOutput("ckErr",   {24'd0, err_cnt_o}, 32'(expErr));
        checkOutput("ckValid", {31'd0, hdr_valid_o}, 32'd0);
        checkOutput("ckBusy",  {31'd0, busy_o}, 32'd0);
`endif

        applyStimulus(8'hA5);
        applyStimulus(8'h80);
        for (int i = 0; i < 10; i++) applyStimulus(8'(i + 8'h10));
        idleCycles(TO - 3);
        checkOutput("toNotYet", {31'd0, busy_o}, 32'd1);
        checkOutput("toErrNotYet", {24'd0, err_cnt_o}, 32'(expErr));
        idleCycles(4);
        expErr++;
        checkOutput("toErr",  {24'd0, err_cnt_o}, 32'(expErr));
        checkOutput("toBusy", {31'd0, busy_o}, 32'd0);

        applyStimulus(8'hA5);
        applyStimulus(8'h80);
        for (int i = 0; i <= 50; i++) applyStimulus(payloadByte(1'b1, i));
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        checkOutput("midRstBusy",  {31'd0, busy_o}, 32'd0);
        checkOutput("midRstValid", {31'd0, hdr_valid_o}, 32'd0);
        checkOutput("midRstErr",   {24'd0, err_cnt_o}, 32'd0);
        checkOutput("midRstOvr",   {24'd0, ovr_cnt_o}, 32'd0);

        sendFrame(1'b0, 1'b0);
        checkOutput("postRstValid", {31'd0, hdr_valid_o}, 32'd1);
        rd_addr_i = 5'd31; #1;
        checkOutput("postRstWord31", rd_data_o, 32'h7C7D7E7F);

        for (int i = 0; i < 260; i++) applyStimulus(8'(i));
        checkOutput("ovrSaturate", {24'd0, ovr_cnt_o}, 32'd255);
        checkOutput("ovrStillValid", {31'd0, hdr_valid_o}, 32'd1);

        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        checkOutput("holdRstValid", {31'd0, hdr_valid_o}, 32'd0);
        checkOutput("holdRstOvr",   {24'd0, ovr_cnt_o}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
